// File: rtl/bus_monitor_pkg.sv
// bus_monitor_pkg: monitor FSM states and the fixed-width part of a log entry
package bus_monitor_pkg;
    typedef enum logic [1:0] {RUN, HALTED, TIMEOUT} state_e;
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  be;
        logic        we;
    } log_payload_t;
    localparam int PAYLOAD_W = $bits(log_payload_t);
endpackage

// File: rtl/bus_monitor_sync_fifo.sv
// sync_fifo: wrap-bit pointer FIFO; a push into a full FIFO succeeds when a pop lands on the same edge
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);
    logic [PW:0] wr_q, wr_d, rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic pop_ok, push_ok;
    assign empty   = wr_q == rd_q;
    assign full    = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = empty ? '0 : mem_q[rd_q[PW-1:0]];
    always_comb begin
        mem_d = mem_q;
        wr_d  = push_ok ? wr_q + 1'b1 : wr_q;
        rd_d  = pop_ok ? rd_q + 1'b1 : rd_q;
        if (push_ok) mem_d[wr_q[PW-1:0]] = wdata;
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_q  <= '0;
            rd_q  <= '0;
            mem_q <= '{default: '0};
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            mem_q <= mem_d;
        end
    end
endmodule

// File: rtl/bus_monitor.sv
// bus_monitor: passive halt/timeout detector and MMIO write logger; BUS_MONITOR_READ_LOG_EN also logs MMIO reads
module bus_monitor
    import bus_monitor_pkg::*;
#(
    parameter int          AW             = 32,
    parameter logic [AW-1:0] MMIO_BASE    = 'h0000_0800,
    parameter logic [AW-1:0] MMIO_MASK    = 'h0000_0800,
    parameter logic [AW-1:0] HALT_ADDR    = 'h0000_0FFC,
    parameter int          LOG_DEPTH      = 8,
    parameter int          TIMEOUT_CYCLES = 2000
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [AW-1:0] address,
    input  logic [31:0]   data_out,
    input  logic [3:0]    byte_enable,
    input  logic          we,
    output logic          log_valid,
    input  logic          log_ready,
    output logic [AW-1:0] log_addr,
    output logic [31:0]   log_data,
    output logic [3:0]    log_be,
    output logic          log_we,
    output logic [15:0]   drop_count,
    output logic [31:0]   cycle_count,
    output logic          halt,
    output logic          timeout
);
    localparam int EW = AW + PAYLOAD_W;
    state_e state_q, state_d;
    logic [31:0] cycle_count_q, cycle_count_d;
    logic [15:0] drop_count_q, drop_count_d;
    logic run, mmio_hit, push, pop, to_hit, full, empty;
    log_payload_t wr_pl, rd_pl;
    always_comb begin
        run      = state_q == RUN;
        mmio_hit = (address & MMIO_MASK) == MMIO_BASE;
`ifdef BUS_MONITOR_READ_LOG_EN
        push     = run && mmio_hit;
`else
        push     = run && mmio_hit && we;
`endif
        pop      = !empty && log_ready;
        to_hit   = (TIMEOUT_CYCLES != 0) && (cycle_count_q == 32'(TIMEOUT_CYCLES - 1));
        // halt has priority when both fire on the same edge
        state_d  = !run ? state_q : (address == HALT_ADDR) ? HALTED : to_hit ? TIMEOUT : RUN;
        cycle_count_d = (run && cycle_count_q != '1) ? cycle_count_q + 1'b1 : cycle_count_q;
        drop_count_d  = (push && full && !pop && drop_count_q != '1) ? drop_count_q + 1'b1 : drop_count_q;
        wr_pl    = '{data: data_out, be: byte_enable, we: we};
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= RUN;
            cycle_count_q <= '0;
            drop_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            cycle_count_q <= cycle_count_d;
            drop_count_q  <= drop_count_d;
        end
    end
    sync_fifo #(.WIDTH(EW), .DEPTH(LOG_DEPTH)) u_fifo (
        .clk   (clk),
        .resetn(resetn),
        .push  (push),
        .pop   (pop),
        .wdata ({address, wr_pl}),
        .rdata ({log_addr, rd_pl}),
        .full  (full),
        .empty (empty)
    );
    assign log_valid   = !empty;
    assign log_data    = rd_pl.data;
    assign log_be      = rd_pl.be;
    assign log_we      = rd_pl.we;
    assign drop_count  = drop_count_q;
    assign cycle_count = cycle_count_q;
    assign halt        = state_q == HALTED;
    assign timeout     = state_q == TIMEOUT;
endmodule

// File: tb/tb_bus_monitor.sv
// tb_bus_monitor: vector table plus scoreboard for bus_monitor, with a second instance for the timeout budget
module tb_bus_monitor;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn, resetn_to;
    logic [31:0] address, data_out, to_addr;
    logic [3:0]  byte_enable;
    logic        we, log_ready, t_we, t_ready;
    logic        log_valid, log_we, halt, timeout;
    logic [31:0] log_addr, log_data, cycle_count;
    logic [3:0]  log_be;
    logic [15:0] drop_count;
    logic        t_valid, t_log_we, t_halt, t_timeout;
    logic [31:0] t_addr, t_data, t_cycle;
    logic [3:0]  t_be;
    logic [15:0] t_drop;

    int checks = 0, errors = 0, ncyc = 0, n = 0;

`ifdef BUS_MONITOR_READ_LOG_EN
    localparam bit READ_LOG = 1'b1;
`else
    localparam bit READ_LOG = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        we;
    } ent_t;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        we;
        logic        exp_log;
    } vec_t;
    ent_t sb[$];
    ent_t e;
    vec_t vecs[8];

    bus_monitor dut (
        .clk(clk), .resetn(resetn), .address(address), .data_out(data_out),
        .byte_enable(byte_enable), .we(we), .log_valid(log_valid), .log_ready(log_ready),
        .log_addr(log_addr), .log_data(log_data), .log_be(log_be), .log_we(log_we),
        .drop_count(drop_count), .cycle_count(cycle_count), .halt(halt), .timeout(timeout)
    );

    bus_monitor #(.TIMEOUT_CYCLES(20)) dut_to (
        .clk(clk), .resetn(resetn_to), .address(to_addr), .data_out(data_out),
        .byte_enable(byte_enable), .we(t_we), .log_valid(t_valid), .log_ready(t_ready),
        .log_addr(t_addr), .log_data(t_data), .log_be(t_be), .log_we(t_log_we),
        .drop_count(t_drop), .cycle_count(t_cycle), .halt(t_halt), .timeout(t_timeout)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
        ncyc++;
    endtask

    task automatic drv(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                       input logic w, input bit exp_push);
        address = a;
        data_out = d;
        byte_enable = b;
        we = w;
        if (exp_push) sb.push_back(ent_t'{a, d, b, w});
    endtask

    // every pop the DUT is about to take must match the oldest expected entry
    always @(negedge clk) begin
        if (resetn && log_valid && log_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL log_pop: unexpected entry addr %0h, none expected", log_addr);
            end else begin
                e = sb.pop_front();
                if ({log_addr, log_data, log_be, log_we} !== {e.addr, e.data, e.be, e.we}) begin
                    errors++;
                    $display("FAIL log_entry: got %0h/%0h/%0h/%0h expected %0h/%0h/%0h/%0h",
                             log_addr, log_data, log_be, log_we, e.addr, e.data, e.be, e.we);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        resetn = 0; resetn_to = 0; address = 32'h100; data_out = 0; byte_enable = 0;
        we = 0; log_ready = 0; to_addr = 32'h100; t_we = 0; t_ready = 1;
        vecs[0] = '{32'h804,  32'hDEADBEEF, 4'hF, 1'b1, 1'b1};
        vecs[1] = '{32'h404,  32'h12345678, 4'hF, 1'b1, 1'b0};
        vecs[2] = '{32'h808,  32'h000000AA, 4'h1, 1'b1, 1'b1};
        vecs[3] = '{32'h808,  32'h55AA55AA, 4'hF, 1'b0, READ_LOG};
        vecs[4] = '{32'h1800, 32'h0BADF00D, 4'h8, 1'b1, 1'b1};
        vecs[5] = '{32'h7FC,  32'h11112222, 4'hF, 1'b1, 1'b0};
        vecs[6] = '{32'hC00,  32'h33334444, 4'h3, 1'b1, 1'b1};
        vecs[7] = '{32'h900,  32'h01020304, 4'h6, 1'b1, 1'b1};
        #12;
        chk("rst_valid", log_valid, 0);
        chk("rst_fields", {log_addr, log_data, log_be, log_we}, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_cycle", cycle_count, 0);
        chk("rst_halt", halt, 0);
        chk("rst_timeout", timeout, 0);
        @(posedge clk); #1;
        resetn = 1; ncyc = 0;
        repeat (10) step;
        chk("idle_cycle", cycle_count, 10);
        chk("idle_halt", halt, 0);
        chk("idle_timeout", timeout, 0);
        chk("idle_valid", log_valid, 0);

        log_ready = 1;
        for (int i = 0; i < 8; i++) begin
            drv(vecs[i].addr, vecs[i].data, vecs[i].be, vecs[i].we, vecs[i].exp_log);
            step;
            chk($sformatf("vec%0d_valid", i), log_valid, vecs[i].exp_log);
        end
        drv(32'h100, 0, 0, 0, 0);
        step; step;
        chk("vec_drained_valid", log_valid, 0);
        chk("vec_sb_empty", sb.size(), 0);
        chk("vec_cycle", cycle_count, ncyc);

        log_ready = 0;
        for (int i = 0; i < 10; i++) begin
            drv(32'h800 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF, 1'b1, i < 8);
            step;
        end
        chk("full_drop", drop_count, 2);
        chk("full_valid", log_valid, 1);
        chk("full_head", log_addr, 32'h800);
        log_ready = 1;
        drv(32'h828, 32'hB000_0000, 4'h5, 1'b1, 1'b1);
        step;
        chk("swap_drop", drop_count, 2);
        log_ready = 0;
        drv(32'h82C, 32'hB000_0001, 4'hF, 1'b1, 1'b0);
        step;
        chk("swap_still_full", drop_count, 3);
        drv(32'h100, 0, 0, 0, 0);
        log_ready = 1;
        n = 0;
        while ((sb.size() != 0 || log_valid) && n < 20) begin
            step;
            n++;
        end
        chk("full_drain_sb", sb.size(), 0);
        chk("full_drain_valid", log_valid, 0);

        log_ready = 0;
        while (ncyc < 79) step;
        drv(32'hFFC, 32'hCAFEF00D, 4'hF, 1'b1, 1'b1);
        step;
        chk("halt_set", halt, 1);
        chk("halt_no_timeout", timeout, 0);
        chk("halt_cycle", cycle_count, 80);
        chk("halt_logged", log_valid, 1);
        drv(32'h804, 32'h0000_0011, 4'hF, 1'b1, 1'b0);
        step; step;
        chk("halt_frozen", cycle_count, 80);
        chk("halt_sticky", halt, 1);
        drv(32'h100, 0, 0, 0, 0);
        log_ready = 1;
        n = 0;
        while ((sb.size() != 0 || log_valid) && n < 20) begin
            step;
            n++;
        end
        chk("halt_drain_sb", sb.size(), 0);
        chk("halt_drain_valid", log_valid, 0);

        #2 resetn = 0;
        #1;
        chk("arst_halt", halt, 0);
        chk("arst_cycle", cycle_count, 0);
        chk("arst_drop", drop_count, 0);
        chk("arst_valid", log_valid, 0);
        resetn = 1; ncyc = 0;
        step;
        chk("arst_restart", cycle_count, 1);

        @(posedge clk); #1;
        resetn_to = 1;
        repeat (19) step;
        chk("to_pre_flag", t_timeout, 0);
        chk("to_pre_cycle", t_cycle, 19);
        step;
        chk("to_flag", t_timeout, 1);
        chk("to_no_halt", t_halt, 0);
        chk("to_cycle", t_cycle, 20);
        repeat (3) step;
        chk("to_frozen", t_cycle, 20);
        chk("to_sticky", t_timeout, 1);
        #2 resetn_to = 0;
        #1;
        chk("to_arst_flag", t_timeout, 0);
        chk("to_arst_cycle", t_cycle, 0);
        @(posedge clk); #1;
        resetn_to = 1;
        repeat (19) step;
        to_addr = 32'hFFC;
        step;
        chk("tie_halt", t_halt, 1);
        chk("tie_no_timeout", t_timeout, 0);
        chk("tie_cycle", t_cycle, 20);
        to_addr = 32'h100;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
